fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_ring.sv | 64 ++++++
 rtl/fetch_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam int FETCH_ENTRY_AW    = 32;
  localparam int FETCH_ENTRY_DW    = 32;

  localparam logic [31:0] DEFAULT_IMEM_BASE_ADDR = 32'h0100_0000;

  typedef struct packed {
    logic [FETCH_ENTRY_AW-1:0] pc;
    logic [FETCH_ENTRY_DW-1:0] insn;
    logic                      filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// Entry storage for the fetch queue: allocate at grant, fill in order, pop at head.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = FETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_en,
  input  logic [AWIDTH-1:0] alloc_pc,
  input  logic              fill_en,
  input  logic [DWIDTH-1:0] fill_insn,
  input  logic              pop_en,
  output logic              head_valid,
  output logic [AWIDTH-1:0] head_pc,
  output logic [DWIDTH-1:0] head_insn,
  output logic [PTR_W-1:0]  alloc_cnt,
  output logic [PTR_W-1:0]  unfilled_cnt
);

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] fptr;
  logic [PTR_W-1:0] rptr;

  // Pointers carry one extra bit so full and empty differ only in the MSB.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      fptr <= '0;
      rptr <= '0;
    end else begin
      if (alloc_en) wptr <= wptr + 1'b1;
      if (fill_en)  fptr <= fptr + 1'b1;
      if (pop_en)   rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en && !flush) begin
      mem[wptr[IDX_W-1:0]] <= '{pc: FETCH_ENTRY_AW'(alloc_pc), insn: '0, filled: 1'b0};
    end
    if (fill_en && !flush) begin
      mem[fptr[IDX_W-1:0]].insn   <= FETCH_ENTRY_DW'(fill_insn);
      mem[fptr[IDX_W-1:0]].filled <= 1'b1;
    end
  end

  always_comb begin
    head         = mem[rptr[IDX_W-1:0]];
    head_valid   = (wptr != rptr) && head.filled;
    head_pc      = AWIDTH'(head.pc);
    head_insn    = DWIDTH'(head.insn);
    alloc_cnt    = wptr - rptr;
    unfilled_cnt = wptr - fptr;
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue with redirect flush and response dropping.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                AWIDTH         = 32,
  parameter int                DWIDTH         = 32,
  parameter logic [AWIDTH-1:0] IMEM_BASE_ADDR = AWIDTH'(DEFAULT_IMEM_BASE_ADDR),
  parameter int                DEPTH          = FETCH_QUEUE_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              ins_valid_o,
  input  logic              ins_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int               PTR_W   = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);

  logic [AWIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]  drop_next;
  logic [PTR_W-1:0]  pending;
  logic [PTR_W-1:0]  alloc_cnt;
  logic [PTR_W-1:0]  unfilled_cnt;
  logic              head_valid;
  logic [AWIDTH-1:0] head_pc;
  logic [DWIDTH-1:0] head_insn;
  logic              grant;
  logic              pop;
  logic              fill_en;

  // Allocated entries plus responses still owed to flushed requests bound the in-flight window.
  always_comb begin
    imem_req_o  = !rst && !redirect_i && ((alloc_cnt + drop_cnt) < DEPTH_L);
    imem_addr_o = fetch_pc;
    ins_valid_o = !rst && !redirect_i && head_valid;
    pc_o        = ins_valid_o ? head_pc   : '0;
    insn_o      = ins_valid_o ? head_insn : '0;
    grant       = imem_req_o && imem_gnt_i;
    pop         = ins_valid_o && ins_ready_i;
    fill_en     = !rst && !redirect_i && imem_rvalid_i &&
                  (drop_cnt == '0) && (unfilled_cnt != '0);
    pending     = drop_cnt + unfilled_cnt;
    drop_next   = (imem_rvalid_i && (pending != '0)) ? pending - 1'b1 : pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= IMEM_BASE_ADDR;
      drop_cnt <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & ~AWIDTH'(3);
      drop_cnt <= drop_next;
    end else begin
      if (grant) fetch_pc <= fetch_pc + AWIDTH'(4);
      if (imem_rvalid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_ring #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk          (clk),
    .rst          (rst),
    .flush        (redirect_i),
    .alloc_en     (grant),
    .alloc_pc     (fetch_pc),
    .fill_en      (fill_en),
    .fill_insn    (imem_rdata_i),
    .pop_en       (pop),
    .head_valid   (head_valid),
    .head_pc      (head_pc),
    .head_insn    (head_insn),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (pop) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (ins_ready_i && !ins_valid_o) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
